// File: rtl/lfu_finder.sv
// LFU replacement-policy unit for a 4-entry buffer pool.
// Define LFU_AGING_EN to halve all counters instead of saturating.
module lfu_finder #(
    parameter int unsigned CNT_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_buf_req,
    input  logic [1:0] ref_buf_numbr,
    output logic [1:0] buf_num_replc
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] access_time_0, access_time_1, access_time_2, access_time_3;
    logic [CNT_W-1:0] cnt   [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [CNT_W-1:0] min_val;
    logic [1:0]       n_buf_num_replc;

    always_comb begin
        cnt[0] = access_time_0;
        cnt[1] = access_time_1;
        cnt[2] = access_time_2;
        cnt[3] = access_time_3;
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        n_buf_num_replc = 2'd0;
        min_val         = cnt[0];
        for (int i = 1; i < 4; i++) begin
            if (cnt[i] < min_val) begin
                min_val         = cnt[i];
                n_buf_num_replc = 2'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt[i];
        end
        if (new_buf_req) begin
            cnt_d[n_buf_num_replc] = '0;
        end else if (cnt[ref_buf_numbr] == CntMax) begin
`ifdef LFU_AGING_EN
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = cnt[i] >> 1;
            end
            cnt_d[ref_buf_numbr] = (cnt[ref_buf_numbr] >> 1) + 1'b1;
`else
            cnt_d[ref_buf_numbr] = CntMax;
`endif
        end else begin
            cnt_d[ref_buf_numbr] = cnt[ref_buf_numbr] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            access_time_0 <= '0;
            access_time_1 <= '0;
            access_time_2 <= '0;
            access_time_3 <= '0;
            buf_num_replc <= 2'd0;
        end else begin
            access_time_0 <= cnt_d[0];
            access_time_1 <= cnt_d[1];
            access_time_2 <= cnt_d[2];
            access_time_3 <= cnt_d[3];
            if (new_buf_req) begin
                buf_num_replc <= n_buf_num_replc;
            end
        end
    end

endmodule

// File: tb/tb_lfu_finder.sv
// Scoreboard bench for lfu_finder: requests push expected indices, a monitor pops them.
module tb_lfu_finder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_buf_req;
    logic [1:0] ref_buf_numbr;
    logic [1:0] buf_num_replc;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];
    logic       pend = 1'b0;

    lfu_finder #(.CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .new_buf_req   (new_buf_req),
        .ref_buf_numbr (ref_buf_numbr),
        .buf_num_replc (buf_num_replc)
    );

    always #5 clk = ~clk;

    // A request accepted at this edge makes a result visible afterwards.
    always @(posedge clk) pend <= new_buf_req && !rst_n;

    always @(negedge clk) begin
        if (pend) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL req_out: output %0d with no expected entry", buf_num_replc);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (buf_num_replc !== e) begin
                    n_bad++;
                    $display("FAIL req_out: got %0d expected %0d", buf_num_replc, e);
                end
            end
        end
    end

    task automatic cyc(input logic req, input logic [1:0] r, input logic [1:0] e);
        new_buf_req   = req;
        ref_buf_numbr = r;
        if (req) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic refs(input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, r, 2'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            new_buf_req   = 1'b0;
            ref_buf_numbr = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
    endtask

    task automatic chk_cnt(input string nm, input logic [3:0] c0, input logic [3:0] c1,
                           input logic [3:0] c2, input logic [3:0] c3);
        logic [15:0] got, want;
        got  = {dut.access_time_3, dut.access_time_2, dut.access_time_1, dut.access_time_0};
        want = {c3, c2, c1, c0};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: counters{3,2,1,0}=%h expected %h", nm, got, want);
        end
    endtask

    task automatic chk_out(input string nm, input logic [1:0] e);
        n_cmp++;
        if (buf_num_replc !== e) begin
            n_bad++;
            $display("FAIL %s: buf_num_replc=%0d expected %0d", nm, buf_num_replc, e);
        end
    endtask

    initial begin
        rst_n = 1'b1; new_buf_req = 1'b0; ref_buf_numbr = 2'd0;
        #1;
        // Reset with random refs, then request on all-equal counters.
        do_reset(2);
        chk_cnt("reset_cnt", 0, 0, 0, 0);
        chk_out("reset_out", 2'd0);
        cyc(1'b1, 2'd3, 2'd0);

        // Basic LFU.
        do_reset(1);
        cyc(1'b0, 2'd1, 0); cyc(1'b0, 2'd1, 0); cyc(1'b0, 2'd2, 0); cyc(1'b0, 2'd3, 0);
        chk_cnt("basic_cnt", 0, 2, 1, 1);
        cyc(1'b1, 2'd1, 2'd0);
        chk_cnt("basic_clr", 0, 2, 1, 1);

        // Tie-break and clear; ref during request is not counted.
        do_reset(1);
        refs(2'd0, 2); refs(2'd1, 2); refs(2'd2, 1); refs(2'd3, 1);
        chk_cnt("tie_cnt", 2, 2, 1, 1);
        cyc(1'b1, 2'd3, 2'd2);
        chk_cnt("tie_clr", 2, 2, 0, 1);

        // Back-to-back requests on {3,0,2,1}.
        do_reset(1);
        refs(2'd0, 3); refs(2'd2, 2); refs(2'd3, 1);
        chk_cnt("b2b_pre", 3, 0, 2, 1);
        cyc(1'b1, 2'd0, 2'd1);
        cyc(1'b1, 2'd2, 2'd1);
        chk_cnt("b2b_post", 3, 0, 2, 1);
        new_buf_req = 1'b0;
        chk_out("b2b_hold", 2'd1);
        cyc(1'b0, 2'd0, 0);
        chk_out("b2b_hold2", 2'd1);

        // Reset mid-operation from {4,5,6,7} with output 2.
        do_reset(1);
        refs(2'd0, 1); refs(2'd1, 1);
        cyc(1'b1, 2'd0, 2'd2);
        refs(2'd0, 3); refs(2'd1, 4); refs(2'd2, 6); refs(2'd3, 7);
        chk_cnt("mid_pre", 4, 5, 6, 7);
        chk_out("mid_pre_out", 2'd2);
        do_reset(1);
        chk_cnt("mid_rst", 0, 0, 0, 0);
        chk_out("mid_rst_out", 2'd0);
        refs(2'd1, 1);
        chk_cnt("mid_resume", 0, 1, 0, 0);

        // Saturation / aging.
        do_reset(1);
        refs(2'd0, 4); refs(2'd3, 16);
`ifdef LFU_AGING_EN
        chk_cnt("sat16", 2, 0, 0, 8);
        refs(2'd3, 4);
        chk_cnt("sat20", 2, 0, 0, 12);
`else
        chk_cnt("sat16", 4, 0, 0, 15);
        refs(2'd3, 4);
        chk_cnt("sat20", 4, 0, 0, 15);
`endif
        cyc(1'b1, 2'd3, 2'd1);
        new_buf_req = 1'b0;
        @(posedge clk); #1;

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expected results never observed", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lfu_finder.md
Name: lfu_finder

Overview:
- Tracks reference frequency of a 4-entry buffer pool and nominates the least-frequently-used (LFU) buffer for replacement.
- One buffer number is referenced every clock, which bumps that buffer's access counter.
- A new-buffer request latches the LFU index onto the output and clears that buffer's counter, because it is being refilled.
- Sits beside the buffer manager / cache controller as its replacement-policy unit.

Parameters:
- CNT_W, 4, width of each per-buffer access counter (saturating; max 2^CNT_W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-HIGH: 1 resets at the next rising edge. The codebase port name is kept despite the _n suffix.
- new_buf_req  input  1  replacement request; sampled each rising edge.
- ref_buf_numbr  input  2  index (0..3) of the buffer referenced this cycle.
- buf_num_replc  output  2  registered index of the buffer to replace.

Behaviour:
- State:
  - Four counters access_time_0..3, each CNT_W bits.
  - Output register buf_num_replc.
  - Internal combinational argmin n_buf_num_replc.
- Reset (rst_n=1 at a rising edge):
  - All counters go to 0 and buf_num_replc goes to 0.
  - Inputs are ignored that cycle.
  - Reset mid-operation discards all history.
- Argmin (combinational):
  - n_buf_num_replc = index of the smallest counter.
  - Ties resolve to the lowest index; e.g. all equal gives 0.
- Normal cycle (rst_n=0, new_buf_req=0):
  - access_time[ref_buf_numbr] += 1, saturating at 2^CNT_W-1 (never wraps).
  - Other counters hold; buf_num_replc holds.
- Request cycle (rst_n=0, new_buf_req=1):
  - buf_num_replc <= n_buf_num_replc, evaluated on pre-edge counter values.
  - access_time[n_buf_num_replc] <= 0.
  - ref_buf_numbr is ignored that cycle (no increment).
- Latency: the chosen index is visible on buf_num_replc one cycle after the request edge. The output then holds until the next request or reset.
- Back-to-back requests: each one re-evaluates argmin on the current counters. The just-cleared buffer is 0, so it is typically selected again unless a lower index is also 0.
- ref_buf_numbr is always considered valid; there is no separate valid strobe.
- No X propagation: all registers are reset, and argmin is fully defined for all counter values.

Optional Feature:
- Macro: LFU_AGING_EN.
- Defined:
  - On a normal cycle where the increment would take the referenced counter past saturation, all four counters shift right by 1 (halve) instead.
  - The referenced counter is then halved and incremented.
  - This keeps the history adaptive.
- Undefined: plain saturating counters as specified above.
- The output, argmin and request behaviour are identical in both builds.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles with random refs -> all counters 0, buf_num_replc=0. Then a request with all counters equal -> buf_num_replc=0.
- Basic LFU:
  - After reset, refs 1,1,2,3 with new_buf_req=0 -> counters {0,2,1,1}.
  - Next cycle new_buf_req=1 -> buf_num_replc=0 on the following cycle; counter0 stays 0.
- Tie-break and clear:
  - Refs 0,0,1,1,2,3 -> counters {2,2,1,1}.
  - Request -> buf_num_replc=2; counters become {2,2,0,1}.
  - Ref of that request cycle is not counted.
- Saturation (LFU_AGING_EN undefined, CNT_W=4): ref 3 for 20 consecutive cycles -> access_time_3=15, no wrap.
  - Aging build: the 16th ref halves all counters, giving access_time_3=8 with the others halved.
- Back-to-back request:
  - Counters {3,0,2,1}, new_buf_req high 2 cycles -> buf_num_replc=1 after both edges.
  - Counters {3,0,2,1} unchanged; the output holds 1 after new_buf_req drops.
- Reset mid-operation:
  - Counters {4,5,6,7} and buf_num_replc=2, then rst_n=1 for one cycle -> all counters 0, buf_num_replc=0.
  - Counting resumes on the next cycle.
